id_ex_pipe_reg: RTL

//  ID/EX pipeline register with integrated load-use hazard detection for the 5-stage MIPS core.
//  - Captures decoded operands and control from ID.
//  - Drives ID_EX_rs / ID_EX_rt / ID_EX_RegWrite / ID_EX_Write_register into the EX forwarding unit and datapath.
//  - Inserts bubbles on load-use hazards, on branch flush and on memory hold.

---
 rtl/id_ex_pipe_reg.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS core.
// Captures decoded operands/control from ID, inserts bubbles on load-use,
// branch flush, and freezes on memory hold.
// Optional: define HAZARD_STATS_EN to add saturating bubble/load-use counters.
module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Hold,
  input  logic               Flush,
  input  logic               ID_valid,
  input  logic [REG_AW-1:0]  ID_rs,
  input  logic [REG_AW-1:0]  ID_rt,
  input  logic [REG_AW-1:0]  ID_rd,
  input  logic               ID_uses_rt,
  input  logic [DATA_W-1:0]  ID_Data1,
  input  logic [DATA_W-1:0]  ID_Data2,
  input  logic [DATA_W-1:0]  ID_Imm,
  input  logic [DATA_W-1:0]  ID_PC_plus4,
  input  logic               ID_RegWrite,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_MemtoReg,
  input  logic               ID_ALUSrc,
  input  logic               ID_RegDst,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  output logic               ID_EX_valid,
  output logic [REG_AW-1:0]  ID_EX_rs,
  output logic [REG_AW-1:0]  ID_EX_rt,
  output logic [REG_AW-1:0]  ID_EX_rd,
  output logic [DATA_W-1:0]  ID_EX_Data1,
  output logic [DATA_W-1:0]  ID_EX_Data2,
  output logic [DATA_W-1:0]  ID_EX_Imm,
  output logic [DATA_W-1:0]  ID_EX_PC_plus4,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemRead,
  output logic               ID_EX_MemWrite,
  output logic               ID_EX_MemtoReg,
  output logic               ID_EX_ALUSrc,
  output logic               ID_EX_RegDst,
  output logic [ALUOP_W-1:0] ID_EX_ALUOp,
  output logic [REG_AW-1:0]  ID_EX_Write_register,
`ifdef HAZARD_STATS_EN
  output logic [31:0]        bubble_count,
  output logic [31:0]        lu_stall_count,
`endif
  output logic               PC_Write,
  output logic               IF_ID_Write
);

  logic              lu;
  logic              ld_bubble;
  logic              lu_stall;
  logic [REG_AW-1:0] wr_reg;

  // Load in EX whose destination is read by the instruction in ID.
  assign lu = ID_valid & ID_EX_valid & ID_EX_MemRead
            & (ID_EX_Write_register != '0)
            & ((ID_EX_Write_register == ID_rs)
               | (ID_uses_rt & (ID_EX_Write_register == ID_rt)));

  // Flush outranks load-use: a wrong-path instruction never needs a stall.
  assign ld_bubble   = ~Hold & (Flush | lu);
  assign lu_stall    = ~Hold & ~Flush & lu;
  assign PC_Write    = ~Hold & ~lu_stall;
  assign IF_ID_Write = ~Hold & ~lu_stall;
  assign wr_reg      = ID_RegDst ? ID_rd : ID_rt;

  // Pipeline register: hold > bubble > load; invalid entries carry no control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_valid          <= 1'b0;
      ID_EX_rs             <= '0;
      ID_EX_rt             <= '0;
      ID_EX_rd             <= '0;
      ID_EX_Data1          <= '0;
      ID_EX_Data2          <= '0;
      ID_EX_Imm            <= '0;
      ID_EX_PC_plus4       <= '0;
      ID_EX_RegWrite       <= 1'b0;
      ID_EX_MemRead        <= 1'b0;
      ID_EX_MemWrite       <= 1'b0;
      ID_EX_MemtoReg       <= 1'b0;
      ID_EX_ALUSrc         <= 1'b0;
      ID_EX_RegDst         <= 1'b0;
      ID_EX_ALUOp          <= '0;
      ID_EX_Write_register <= '0;
    end else if (!Hold) begin
      if (ld_bubble) begin
        ID_EX_valid          <= 1'b0;
        ID_EX_rs             <= '0;
        ID_EX_rt             <= '0;
        ID_EX_rd             <= '0;
        ID_EX_Data1          <= '0;
        ID_EX_Data2          <= '0;
        ID_EX_Imm            <= '0;
        ID_EX_PC_plus4       <= '0;
        ID_EX_RegWrite       <= 1'b0;
        ID_EX_MemRead        <= 1'b0;
        ID_EX_MemWrite       <= 1'b0;
        ID_EX_MemtoReg       <= 1'b0;
        ID_EX_ALUSrc         <= 1'b0;
        ID_EX_RegDst         <= 1'b0;
        ID_EX_ALUOp          <= '0;
        ID_EX_Write_register <= '0;
      end else begin
        ID_EX_valid          <= ID_valid;
        ID_EX_rs             <= ID_rs;
        ID_EX_rt             <= ID_rt;
        ID_EX_rd             <= ID_rd;
        ID_EX_Data1          <= ID_Data1;
        ID_EX_Data2          <= ID_Data2;
        ID_EX_Imm            <= ID_Imm;
        ID_EX_PC_plus4       <= ID_PC_plus4;
        ID_EX_RegWrite       <= ID_valid & ID_RegWrite;
        ID_EX_MemRead        <= ID_valid & ID_MemRead;
        ID_EX_MemWrite       <= ID_valid & ID_MemWrite;
        ID_EX_MemtoReg       <= ID_valid & ID_MemtoReg;
        ID_EX_ALUSrc         <= ID_valid & ID_ALUSrc;
        ID_EX_RegDst         <= ID_valid & ID_RegDst;
        ID_EX_ALUOp          <= ID_valid ? ID_ALUOp : '0;
        ID_EX_Write_register <= ID_valid ? wr_reg : '0;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  // Saturating hazard counters; frozen with the stage during Hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count   <= '0;
      lu_stall_count <= '0;
    end else begin
      if (ld_bubble && (bubble_count != 32'hFFFF_FFFF))
        bubble_count <= bubble_count + 32'd1;
      if (lu_stall && (lu_stall_count != 32'hFFFF_FFFF))
        lu_stall_count <= lu_stall_count + 32'd1;
    end
  end
`endif

endmodule
